dmem_ctrl: RTL
==============

DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter WIDTH, default 32, data and address width.
REQ-002 Parameter TIMEOUT, default 16, maximum cycles waited for mem_gnt_i or mem_rvalid_i before abort; legal range 2..255.
REQ-003 clk_i  in  1  single system clock; all state changes on the rising edge.
REQ-004 rst_i  in  1  asynchronous, active-low reset.
REQ-005 cpu_re_i  in  1  core load request (level, held while stalled).
REQ-006 cpu_we_i  in  1  core store request (level, held while stalled).
REQ-007 cpu_addr_i  in  WIDTH  core byte address (ALU result).
REQ-008 cpu_wdata_i  in  WIDTH  core store data.
REQ-009 cpu_rdata_o  out  WIDTH  load data returned to core result mux.
REQ-010 stall_o  out  1  high = core holds PC and instruction (drives inverted PC enable).
REQ-011 err_o  out  1  one-cycle pulse on misaligned access or timeout.
REQ-012 mem_req_o  out  1  bus request.
REQ-013 mem_we_o  out  1  bus write qualifier, valid with mem_req_o.
REQ-014 mem_addr_o  out  WIDTH  bus word address, valid with mem_req_o.
REQ-015 mem_wdata_o  out  WIDTH  bus write data, valid with mem_req_o.
REQ-016 mem_gnt_i  in  1  bus accepts the request in the cycle where mem_req_o and mem_gnt_i are both high.
REQ-017 mem_rvalid_i  in  1  read data valid, one cycle, at least one cycle after grant.
REQ-018 mem_rdata_i  in  WIDTH  read data, valid with mem_rvalid_i.

Function
REQ-019 The FSM SHALL have states IDLE, REQ, WAIT_R, DONE.
REQ-020 Access = cpu_re_i|cpu_we_i; when both are high, the access SHALL be a store.
REQ-021 In IDLE with an aligned access, the block SHALL assert mem_req_o and stall_o combinationally; with gnt, next state is WAIT_R (load) or DONE (store); without gnt, REQ.
REQ-022 In REQ, mem_req_o SHALL stay high with address/data/we stable until gnt; then WAIT_R (load) or DONE (store).
REQ-023 In WAIT_R, on mem_rvalid_i the block SHALL register mem_rdata_i into cpu_rdata_o and go to DONE.
REQ-024 In DONE, stall_o SHALL be low, cpu_rdata_o SHALL hold the captured data, and next state SHALL be IDLE unconditionally.
REQ-025 stall_o SHALL be high in REQ and WAIT_R, and in IDLE only while an access is present.
REQ-026 Minimum latency: store with immediate gnt = 1 stall cycle; load with immediate gnt and rvalid the next cycle = 2 stall cycles.
REQ-027 mem_addr_o SHALL equal {cpu_addr_i[WIDTH-1:2], 2'b00}; mem_wdata_o SHALL equal cpu_wdata_i.
REQ-028 If cpu_addr_i[1:0] != 0 in IDLE with an access, no bus request SHALL be issued; err_o pulses, cpu_rdata_o is forced to 0, and the state goes to DONE.
REQ-029 A wait counter SHALL clear on entry to REQ/WAIT_R and increment every cycle spent there; on reaching TIMEOUT the block SHALL drop mem_req_o, pulse err_o, force cpu_rdata_o to 0, and go to DONE.
REQ-030 An mem_rvalid_i outside WAIT_R SHALL be ignored; a gnt in the same cycle as a timeout SHALL take precedence over the timeout.
REQ-031 With no access in IDLE, all bus outputs except address/data SHALL be low and stall_o low.

Reset
REQ-032 On rst_i low, the block SHALL immediately go to IDLE, zero the counter and cpu_rdata_o, and force mem_req_o, stall_o, and err_o low, including mid-transaction.
REQ-033 After rst_i rises, the first access SHALL be sampled on the next rising edge.

Structure
REQ-034 The state encoding and the TIMEOUT default SHALL live in the shared package rv32_pkg.
REQ-035 The wait counter SHALL be one sub-module, wait_cntr (clear, enable, limit, expired), instantiated once.

Verification
REQ-036 Store addr 0x100, data 0xA5A5A5A5, gnt held high -> one cycle req/we, stall high for 1 cycle, err_o 0.
REQ-037 Load addr 0x104, gnt after 3 cycles, rvalid 2 cycles later with 0x12345678 -> stall high for 6 cycles, cpu_rdata_o=0x12345678 in DONE.
REQ-038 Load addr 0x102 -> no mem_req_o, err_o pulse, cpu_rdata_o=0, stall high for 1 cycle.
REQ-039 Load with gnt never asserted, TIMEOUT=16 -> mem_req_o drops after 16 cycles, err_o pulses, core released.
REQ-040 rst_i low while in WAIT_R -> outputs reset immediately; a late rvalid after release is ignored, and the next store completes normally.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared definitions for the data-memory controller: FSM encoding and wait-limit defaults.
package rv32_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2,
    DONE   = 2'd3
  } dmem_state_e;

  localparam int unsigned DMEM_TIMEOUT = 16;
  localparam int unsigned CNT_W        = 8;

endpackage

// File: rtl/wait_cntr.sv
// Bus wait counter: counts cycles since the last clear and flags the cycle
// in which the count reaches the configured limit.
module wait_cntr
  import rv32_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic             expired_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Expired marks the limit-th enabled cycle, so the owner can still act in it.
  assign expired_o = en_i && (cnt_q == (limit_i - CNT_W'(1)));

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: turns core load/store levels into a req/gnt/rvalid
// bus handshake, stalling the core until the access completes or aborts.
module dmem_ctrl
  import rv32_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = DMEM_TIMEOUT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cpu_re_i,
  input  logic             cpu_we_i,
  input  logic [WIDTH-1:0] cpu_addr_i,
  input  logic [WIDTH-1:0] cpu_wdata_i,
  output logic [WIDTH-1:0] cpu_rdata_o,
  output logic             stall_o,
  output logic             err_o,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic [WIDTH-1:0] mem_addr_o,
  output logic [WIDTH-1:0] mem_wdata_o,
  input  logic             mem_gnt_i,
  input  logic             mem_rvalid_i,
  input  logic [WIDTH-1:0] mem_rdata_i
);

  dmem_state_e      state_q;
  logic [WIDTH-1:0] rdata_q;
  logic             err_q;

  logic access;
  logic isStore;
  logic aligned;
  logic cntClr;
  logic cntEn;
  logic cntExpired;

  assign access  = cpu_re_i | cpu_we_i;
  assign isStore = cpu_we_i;
  assign aligned = (cpu_addr_i[1:0] == 2'b00);

  // Request and stall are gated by reset so the core is released the instant reset asserts.
  assign mem_req_o   = rst_i && (((state_q == IDLE) && access && aligned) || (state_q == REQ));
  assign mem_we_o    = mem_req_o && isStore;
  assign mem_addr_o  = {cpu_addr_i[WIDTH-1:2], 2'b00};
  assign mem_wdata_o = cpu_wdata_i;
  assign stall_o     = rst_i && (((state_q == IDLE) && access) ||
                                 (state_q == REQ) || (state_q == WAIT_R));
  assign err_o       = err_q;
  assign cpu_rdata_o = rdata_q;

  assign cntClr = (state_q == IDLE) || ((state_q == REQ) && mem_gnt_i);
  assign cntEn  = (state_q == REQ) || (state_q == WAIT_R);

  wait_cntr u_waitCntr (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (cntClr),
    .en_i     (cntEn),
    .limit_i  (CNT_W'(TIMEOUT)),
    .expired_o(cntExpired)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (access) begin
            if (!aligned) begin
              err_q   <= 1'b1;
              rdata_q <= '0;
              state_q <= DONE;
            end else if (mem_gnt_i) begin
              state_q <= isStore ? DONE : WAIT_R;
            end else begin
              state_q <= REQ;
            end
          end
        end
        // A grant arriving in the expiry cycle still wins over the abort.
        REQ: begin
          if (mem_gnt_i) begin
            state_q <= isStore ? DONE : WAIT_R;
          end else if (cntExpired) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
            state_q <= DONE;
          end
        end
        WAIT_R: begin
          if (mem_rvalid_i) begin
            rdata_q <= mem_rdata_i;
            state_q <= DONE;
          end else if (cntExpired) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
            state_q <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
